// File: rtl/mt9v_pkg.sv
// Shared definitions for the MT9V pixel-bus transmitter.
//  - state_t      : frame/line timing states
//  - PAT_*        : test-pattern selector codes
//  - DEF_*        : MT9V default timing (752x480 active)
//  - max_of       : elaboration-time helper for counter sizing
package mt9v_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_F2L,
      ST_ACTIVE,
      ST_HBLANK,
      ST_L2F,
      ST_FBLANK
   } state_t;

   localparam logic [1:0] PAT_HRAMP = 2'd0;
   localparam logic [1:0] PAT_VRAMP = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_CONST = 2'd3;

   localparam int DEF_H_ACTIVE    = 752;
   localparam int DEF_H_BLANK     = 94;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_F2L         = 4;
   localparam int DEF_L2F         = 4;
   localparam int DEF_FRAME_BLANK = 1000;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mt9v_pattern.sv
// Combinational test-pattern generator. The parent registers the result
// together with line-valid so data and ln leave the block aligned.
// Ports:
//   pattern   : pattern selector (PAT_* codes)
//   const_val : pixel value for the constant pattern
//   x, y      : low 8 bits of pixel / line position (ramps wrap mod 256)
//   pix       : generated pixel value
module mt9v_pattern
   import mt9v_pkg::*;
(
   input  logic [1:0] pattern,
   input  logic [7:0] const_val,
   input  logic [7:0] x,
   input  logic [7:0] y,
   output logic [7:0] pix
);

   always_comb begin
      pix = 8'h00;
      case (pattern)
         PAT_HRAMP: pix = x;
         PAT_VRAMP: pix = y;
         // 8x8 checkerboard
         PAT_CHECK: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
         PAT_CONST: pix = const_val;
         default:   pix = 8'h00;
      endcase
   end

endmodule

// File: rtl/mt9v_tx.sv
// MT9V parallel pixel-bus transmitter: generates sensor-accurate frame/line
// timing with synthetic test patterns, standing in for the image sensor.
// Ports:
//   pclk      : pixel clock, all logic on rising edge
//   rst_n     : asynchronous active-low reset
//   enable    : run request, only acted on at frame boundaries
//   pattern   : 0 h-ramp, 1 v-ramp, 2 checker, 3 constant
//   const_val : pixel value for the constant pattern
//   data_out  : registered pixel data (0 while ln_out is low)
//   fm_out    : registered frame valid
//   ln_out    : registered line valid
//   frame_cnt : completed frames, wraps at 16 bits
//   busy      : high whenever the timing FSM is not idle
module mt9v_tx
   import mt9v_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_BLANK     = DEF_H_BLANK,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int F2L         = DEF_F2L,
   parameter int L2F         = DEF_L2F,
   parameter int FRAME_BLANK = DEF_FRAME_BLANK
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [1:0]  pattern,
   input  logic [7:0]  const_val,
   output logic [7:0]  data_out,
   output logic        fm_out,
   output logic        ln_out,
   output logic [15:0] frame_cnt,
   output logic        busy
);

   localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int CMAX = max_of(max_of(F2L, H_BLANK), max_of(L2F, FRAME_BLANK));
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   state_t         state;
   state_t         nxt;
   logic [XW-1:0]  x;
   logic [YW-1:0]  y;
   logic [CW-1:0]  cnt;
   logic [31:0]    lim;
   logic [1:0]     pat_q;
   logic [7:0]     cval_q;
   logic [7:0]     pix;
   logic           x_last;
   logic           y_last;
   logic           cnt_last;
   logic           timed;
   logic           frame_start;

   assign x_last      = (32'(x) == 32'(H_ACTIVE - 1));
   assign y_last      = (32'(y) == 32'(V_ACTIVE - 1));
   assign cnt_last    = (32'(cnt) == lim - 32'd1);
   assign timed       = (state == ST_F2L) || (state == ST_HBLANK) ||
                        (state == ST_L2F) || (state == ST_FBLANK);
   assign frame_start = (nxt == ST_F2L) && (state != ST_F2L);
   assign busy        = (state != ST_IDLE);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   // The shared cycle counter's terminal count depends on the state it serves.
   always_comb begin
      nxt = state;
      lim = 32'd1;
      case (state)
         ST_IDLE: begin
            if (enable) nxt = ST_F2L;
         end
         ST_F2L: begin
            lim = 32'(F2L);
            if (cnt_last) nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (x_last) nxt = y_last ? ST_L2F : ST_HBLANK;
         end
         ST_HBLANK: begin
            lim = 32'(H_BLANK);
            if (cnt_last) nxt = ST_ACTIVE;
         end
         ST_L2F: begin
            lim = 32'(L2F);
            if (cnt_last) nxt = ST_FBLANK;
         end
         ST_FBLANK: begin
            lim = 32'(FRAME_BLANK);
            if (cnt_last) nxt = enable ? ST_F2L : ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   mt9v_pattern u_pattern (
      .pattern   (pat_q),
      .const_val (cval_q),
      .x         (8'(x)),
      .y         (8'(y)),
      .pix       (pix)
   );

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         x         <= '0;
         y         <= '0;
         cnt       <= '0;
         pat_q     <= PAT_HRAMP;
         cval_q    <= 8'h00;
         frame_cnt <= 16'h0000;
         fm_out    <= 1'b0;
         ln_out    <= 1'b0;
         data_out  <= 8'h00;
      end else begin
         // Counter restarts on every state change, so each timed state
         // begins counting from zero.
         if (state != nxt)  cnt <= '0;
         else if (timed)    cnt <= cnt + CW'(1);

         if (state == ST_ACTIVE) x <= x_last ? '0 : x + XW'(1);
         else                    x <= '0;

         if (frame_start)
            y <= '0;
         else if ((state == ST_ACTIVE) && x_last && !y_last)
            y <= y + YW'(1);

         // Pattern selection is frozen for the whole frame.
         if (frame_start) begin
            pat_q  <= pattern;
            cval_q <= const_val;
         end

         if ((state == ST_FBLANK) && cnt_last)
            frame_cnt <= frame_cnt + 16'd1;

         // Bus outputs follow the current state by one register stage;
         // data and ln share that stage so they stay aligned.
         fm_out   <= (state == ST_F2L) || (state == ST_ACTIVE) ||
                     (state == ST_HBLANK) || (state == ST_L2F);
         ln_out   <= (state == ST_ACTIVE);
         data_out <= (state == ST_ACTIVE) ? pix : 8'h00;
      end
   end

endmodule
